// File: rtl/less_check_pkg.sv
// Shared types and the golden less-than model for the less_check response monitor.
package less_check_pkg;

    localparam int COUNT_W = 16;
    localparam int MAX_W   = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_FAIL
    } state_t;

    // Operands arrive zero-extended, so the borrow of this wide subtract equals
    // the borrow of the (WIDTH+1)-bit subtract for any WIDTH up to MAX_W.
    function automatic logic golden_less(input logic [MAX_W-1:0] a,
                                         input logic [MAX_W-1:0] b);
        logic [MAX_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[MAX_W];
    endfunction

endpackage

// File: rtl/less_check_stage.sv
// Stage-1 sample register of less_check plus the golden compute on the held sample.
module less_check_stage
    import less_check_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic             ch_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             c_o,
    output logic             ch_o,
    output logic [WIDTH:0]   diff_o,
    output logic             expected_o,
    output logic             mismatch_o
);

    logic             valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;
    logic             ch_q;

    // A clear wins over a load so a flushed or restarted run never keeps a stale sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            ch_q    <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= load_i;
            if (load_i) begin
                a_q  <= a_i;
                b_q  <= b_i;
                c_q  <= c_i;
                ch_q <= ch_i;
            end
        end
    end

    assign diff_o     = {1'b0, a_q} - {1'b0, b_q};
    assign expected_o = golden_less(MAX_W'(a_q), MAX_W'(b_q));
    assign mismatch_o = valid_q && ((c_q != expected_o) || (ch_q != expected_o));

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign c_o     = c_q;
    assign ch_o    = ch_q;

endmodule

// File: rtl/less_check.sv
// Self-checking response monitor for the less-than comparator tests.
// Optional build macro LESS_CHECK_STOP_ON_FAIL_EN stops the run on the first mismatch.
module less_check
    import less_check_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_TESTS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               c,
    input  logic               ch,
    output logic               done,
    output logic               pass,
    output logic [COUNT_W-1:0] test_count,
    output logic [COUNT_W-1:0] err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic [WIDTH:0]     fail_diff,
    output logic               fail_c,
    output logic               fail_ch
);

    localparam logic [COUNT_W-1:0] LAST_IDX  = COUNT_W'(NUM_TESTS - 1);
    localparam logic [COUNT_W-1:0] TOTAL     = COUNT_W'(NUM_TESTS);
    localparam logic [COUNT_W-1:0] ERR_LIMIT = '1;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] acceptCount_q, acceptCount_d;
    logic [COUNT_W-1:0] testCount_q, testCount_d;
    logic [COUNT_W-1:0] errCount_q, errCount_d;
    logic [WIDTH-1:0]   failA_q, failA_d;
    logic [WIDTH-1:0]   failB_q, failB_d;
    logic [WIDTH:0]     failDiff_q, failDiff_d;
    logic               failC_q, failC_d;
    logic               failCh_q, failCh_d;

    logic               transfer;
    logic               stageClear;
    logic               s1Valid;
    logic [WIDTH-1:0]   s1A;
    logic [WIDTH-1:0]   s1B;
    logic               s1C;
    logic               s1Ch;
    logic [WIDTH:0]     s1Diff;
    logic               s1Expected;
    logic               s1Mismatch;

    assign transfer = in_valid && (state_q == ST_RUN);

    less_check_stage #(
        .WIDTH(WIDTH)
    ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (stageClear),
        .load_i     (transfer),
        .a_i        (a),
        .b_i        (b),
        .c_i        (c),
        .ch_i       (ch),
        .valid_o    (s1Valid),
        .a_o        (s1A),
        .b_o        (s1B),
        .c_o        (s1C),
        .ch_o       (s1Ch),
        .diff_o     (s1Diff),
        .expected_o (s1Expected),
        .mismatch_o (s1Mismatch)
    );

    // Retire logic runs first; the state case and the stop-on-fail override may then
    // replace it, so a restart always wins over a sample still in flight.
    always_comb begin
        state_d       = state_q;
        acceptCount_d = acceptCount_q;
        testCount_d   = testCount_q;
        errCount_d    = errCount_q;
        failA_d       = failA_q;
        failB_d       = failB_q;
        failDiff_d    = failDiff_q;
        failC_d       = failC_q;
        failCh_d      = failCh_q;
        stageClear    = 1'b0;

        if (s1Valid) begin
            testCount_d = testCount_q + 1'b1;
            if (s1Mismatch) begin
                if (errCount_q != ERR_LIMIT) begin
                    errCount_d = errCount_q + 1'b1;
                end
                if (errCount_q == '0) begin
                    failA_d    = s1A;
                    failB_d    = s1B;
                    failDiff_d = s1Diff;
                    failC_d    = s1C;
                    failCh_d   = s1Ch;
                end
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d       = ST_RUN;
                    acceptCount_d = '0;
                    testCount_d   = '0;
                    errCount_d    = '0;
                    failA_d       = '0;
                    failB_d       = '0;
                    failDiff_d    = '0;
                    failC_d       = 1'b0;
                    failCh_d      = 1'b0;
                    stageClear    = 1'b1;
                end
            end
            ST_RUN: begin
                if (transfer) begin
                    acceptCount_d = acceptCount_q + 1'b1;
                    if (acceptCount_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!s1Valid && (testCount_q == TOTAL)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef LESS_CHECK_STOP_ON_FAIL_EN
        if (s1Mismatch) begin
            state_d    = ST_FAIL;
            stageClear = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            acceptCount_q <= '0;
            testCount_q   <= '0;
            errCount_q    <= '0;
            failA_q       <= '0;
            failB_q       <= '0;
            failDiff_q    <= '0;
            failC_q       <= 1'b0;
            failCh_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            acceptCount_q <= acceptCount_d;
            testCount_q   <= testCount_d;
            errCount_q    <= errCount_d;
            failA_q       <= failA_d;
            failB_q       <= failB_d;
            failDiff_q    <= failDiff_d;
            failC_q       <= failC_d;
            failCh_q      <= failCh_d;
        end
    end

    assign in_ready   = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE) || (state_q == ST_FAIL);
    assign pass       = (state_q == ST_DONE) && (errCount_q == '0);
    assign test_count = testCount_q;
    assign err_count  = errCount_q;
    assign fail_a     = failA_q;
    assign fail_b     = failB_q;
    assign fail_diff  = failDiff_q;
    assign fail_c     = failC_q;
    assign fail_ch    = failCh_q;

endmodule

// File: tb/tb_less_check.sv
// Directed, table-driven bench for less_check with WIDTH=8 and NUM_TESTS=4.
module tb_less_check;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       ch;
    } sample_t;

    typedef struct {
        sample_t     s [4];
        logic [15:0] expErr;
        logic        expPass;
        logic [7:0]  expFailA;
        logic [7:0]  expFailB;
        logic [8:0]  expFailDiff;
        logic        expFailC;
        logic        expFailCh;
    } run_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        c;
    logic        ch;
    logic        done;
    logic        pass;
    logic [15:0] test_count;
    logic [15:0] err_count;
    logic [7:0]  fail_a;
    logic [7:0]  fail_b;
    logic [8:0]  fail_diff;
    logic        fail_c;
    logic        fail_ch;

    int   checks;
    int   errors;
    run_t runs [4];

    less_check #(
        .WIDTH     (8),
        .NUM_TESTS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .c          (c),
        .ch         (ch),
        .done       (done),
        .pass       (pass),
        .test_count (test_count),
        .err_count  (err_count),
        .fail_a     (fail_a),
        .fail_b     (fail_b),
        .fail_diff  (fail_diff),
        .fail_c     (fail_c),
        .fail_ch    (fail_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams one four-sample run back to back and checks completion timing and results.
    task automatic applyStimulus(input run_t r);
        pulseStart();
        checkOutput("cleared_test_count", 32'(test_count), 32'd0);
        checkOutput("cleared_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("run_in_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            a        = r.s[i].a;
            b        = r.s[i].b;
            c        = r.s[i].c;
            ch       = r.s[i].ch;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("drain_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("early_done", 32'(done), 32'd0);
        checkOutput("test_count", 32'(test_count), 32'd4);
        @(negedge clk);
        checkOutput("done", 32'(done), 32'd1);
        checkOutput("pass", 32'(pass), 32'(r.expPass));
        checkOutput("err_count", 32'(err_count), 32'(r.expErr));
        checkOutput("fail_a", 32'(fail_a), 32'(r.expFailA));
        checkOutput("fail_b", 32'(fail_b), 32'(r.expFailB));
        checkOutput("fail_diff", 32'(fail_diff), 32'(r.expFailDiff));
        checkOutput("fail_c", 32'(fail_c), 32'(r.expFailC));
        checkOutput("fail_ch", 32'(fail_ch), 32'(r.expFailCh));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
        checkOutput({tag, "_test_count"}, 32'(test_count), 32'd0);
        checkOutput({tag, "_err_count"}, 32'(err_count), 32'd0);
        checkOutput({tag, "_fail_a"}, 32'(fail_a), 32'd0);
        checkOutput({tag, "_fail_b"}, 32'(fail_b), 32'd0);
        checkOutput({tag, "_fail_diff"}, 32'(fail_diff), 32'd0);
        checkOutput({tag, "_fail_c"}, 32'(fail_c), 32'd0);
        checkOutput({tag, "_fail_ch"}, 32'(fail_ch), 32'd0);
    endtask

    initial begin
        int transfers;
        int idx;
        logic sent;

        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        c        = 1'b0;
        ch       = 1'b0;

        runs[0].s[0] = '{8'd3,   8'd5,   1'b1, 1'b1};
        runs[0].s[1] = '{8'd5,   8'd3,   1'b0, 1'b0};
        runs[0].s[2] = '{8'd7,   8'd7,   1'b0, 1'b0};
        runs[0].s[3] = '{8'd0,   8'd255, 1'b1, 1'b1};
        runs[0].expErr = 16'd0; runs[0].expPass = 1'b1;
        runs[0].expFailA = 8'h00; runs[0].expFailB = 8'h00; runs[0].expFailDiff = 9'h000;
        runs[0].expFailC = 1'b0; runs[0].expFailCh = 1'b0;

        runs[1].s[0] = '{8'd1,   8'd2,   1'b1, 1'b1};
        runs[1].s[1] = '{8'd9,   8'd4,   1'b0, 1'b0};
        runs[1].s[2] = '{8'h10,  8'h20,  1'b1, 1'b0};
        runs[1].s[3] = '{8'd4,   8'd4,   1'b0, 1'b0};
        runs[1].expErr = 16'd1; runs[1].expPass = 1'b0;
        runs[1].expFailA = 8'h10; runs[1].expFailB = 8'h20; runs[1].expFailDiff = 9'h1F0;
        runs[1].expFailC = 1'b1; runs[1].expFailCh = 1'b0;

        runs[2].s[0] = '{8'd2,   8'd1,   1'b0, 1'b0};
        runs[2].s[1] = '{8'h80,  8'h01,  1'b1, 1'b0};
        runs[2].s[2] = '{8'hFF,  8'hFE,  1'b0, 1'b0};
        runs[2].s[3] = '{8'h00,  8'h00,  1'b0, 1'b1};
        runs[2].expErr = 16'd2; runs[2].expPass = 1'b0;
        runs[2].expFailA = 8'h80; runs[2].expFailB = 8'h01; runs[2].expFailDiff = 9'h07F;
        runs[2].expFailC = 1'b1; runs[2].expFailCh = 1'b0;

        runs[3].s[0] = '{8'd255, 8'd0,   1'b0, 1'b0};
        runs[3].s[1] = '{8'd0,   8'd0,   1'b0, 1'b0};
        runs[3].s[2] = '{8'd255, 8'd255, 1'b0, 1'b0};
        runs[3].s[3] = '{8'd254, 8'd255, 1'b1, 1'b1};
        runs[3].expErr = 16'd0; runs[3].expPass = 1'b1;
        runs[3].expFailA = 8'h00; runs[3].expFailB = 8'h00; runs[3].expFailDiff = 9'h000;
        runs[3].expFailC = 1'b0; runs[3].expFailCh = 1'b0;

        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            $display("[TB] table run %0d", r);
            applyStimulus(runs[r]);
        end

        // in_valid held high for six cycles: only four samples may be taken.
        $display("[TB] held in_valid sequence");
        pulseStart();
        transfers = 0;
        in_valid  = 1'b1;
        a = 8'd1; b = 8'd2; c = 1'b1; ch = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            checkOutput("hold_in_ready", 32'(in_ready), (cyc < 4) ? 32'd1 : 32'd0);
            if (in_ready) transfers++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("hold_transfers", 32'(transfers), 32'd4);
        checkOutput("hold_test_count", 32'(test_count), 32'd4);
        checkOutput("hold_done", 32'(done), 32'd1);
        checkOutput("hold_pass", 32'(pass), 32'd1);

        // Reset in the middle of a run, then a clean restart.
        $display("[TB] mid-run reset sequence");
        pulseStart();
        in_valid = 1'b1;
        a = 8'd6; b = 8'd9; c = 1'b0; ch = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(runs[0]);

`ifdef LESS_CHECK_STOP_ON_FAIL_EN
        $display("[TB] stop-on-fail sequence");
        runs[0].s[1] = '{8'h40, 8'h10, 1'b1, 1'b1};
        pulseStart();
        idx = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            sent = 1'b0;
            if (in_ready && idx < 4) begin
                in_valid = 1'b1;
                a  = runs[0].s[idx].a;
                b  = runs[0].s[idx].b;
                c  = runs[0].s[idx].c;
                ch = runs[0].s[idx].ch;
                sent = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (sent) idx++;
        end
        in_valid = 1'b0;
        checkOutput("stop_transfers", 32'(idx), 32'd3);
        checkOutput("stop_in_ready", 32'(in_ready), 32'd0);
        checkOutput("stop_done", 32'(done), 32'd1);
        checkOutput("stop_pass", 32'(pass), 32'd0);
        checkOutput("stop_test_count", 32'(test_count), 32'd2);
        checkOutput("stop_err_count", 32'(err_count), 32'd1);
        checkOutput("stop_fail_a", 32'(fail_a), 32'h40);
`else
        idx  = 0;
        sent = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
